pipe_reduce: RTL

Parametrised, fully pipelined bitwise reduction tree over a WIDTH-bit vector, built from FANIN-input levels so each level maps onto one LUT plus a register.
- Operation (OR/AND/XOR) is selectable per beat and travels with the data.
- A valid pipeline carries each beat; a packet accumulator reduces multiple beats into one result.
- Sits wherever the design needs wide any/all/parity flags at high fmax, e.g. error-vector collapse and packet parity.

---
 rtl/pipe_reduce_pkg.sv | 58 +++++
 rtl/pipe_reduce_level.sv | 63 ++++++
 rtl/pipe_reduce.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_reduce_pkg.sv
// Shared definitions for the pipelined bitwise reduction tree.
//   - op encoding (OR/AND/XOR; code 3 behaves as OR)
//   - op_identity / op_apply : single-bit reduction primitives
//   - num_levels / level_width / level_offset : tree geometry, evaluated at
//     elaboration time to size the level chain and its packed data bus
package pipe_reduce_pkg;

    localparam logic [1:0] OP_OR  = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;

    // Neutral element: 1 for AND, 0 for OR/XOR (and the reserved code).
    function automatic logic op_identity(input logic [1:0] op);
        return (op == OP_AND);
    endfunction

    function automatic logic op_apply(input logic [1:0] op, input logic a, input logic b);
        case (op)
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            default: return a | b;
        endcase
    endfunction

    // Smallest L >= 1 with fanin**L >= width.
    function automatic int num_levels(input int width, input int fanin);
        int    lv;
        longint span;
        lv   = 1;
        span = longint'(fanin);
        while (span < longint'(width)) begin
            span = span * longint'(fanin);
            lv++;
        end
        return lv;
    endfunction

    // Number of node outputs after k levels (k=0 is the raw input).
    function automatic int level_width(input int width, input int fanin, input int k);
        int w;
        w = width;
        for (int i = 0; i < k; i++) begin
            w = (w + fanin - 1) / fanin;
        end
        return w;
    endfunction

    // Bit offset of level k inside a bus that concatenates levels 0..k-1.
    function automatic int level_offset(input int width, input int fanin, input int k);
        int off;
        off = 0;
        for (int i = 0; i < k; i++) begin
            off = off + level_width(width, fanin, i);
        end
        return off;
    endfunction

endpackage

// File: rtl/pipe_reduce_level.sv
// One registered level of the reduction tree.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset (valid only)
//   in_valid/in_op/in_last   sidebands from the previous stage
//   in_data  [IN_W]          vector from the previous stage
//   out_valid/out_op/out_last registered sidebands
//   out_data [OUT_W]         one reduced bit per FANIN-wide group
module pipe_reduce_level
    import pipe_reduce_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int FANIN = 6,
    localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_op,
    output logic             out_last
);

    localparam int PAD_W = OUT_W * FANIN;

    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] node;

    // The short last group is filled with this stage's op identity so it
    // cannot disturb the group result.
    always_comb begin
        logic acc_v;
        padded            = {PAD_W{op_identity(in_op)}};
        padded[IN_W-1:0]  = in_data;
        node              = '0;
        for (int g = 0; g < OUT_W; g++) begin
            acc_v = op_identity(in_op);
            for (int j = 0; j < FANIN; j++) begin
                acc_v = op_apply(in_op, acc_v, padded[g*FANIN + j]);
            end
            node[g] = acc_v;
        end
    end

    // ---- stage boundary: valid is the only reset state ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        out_data <= node;
        out_op   <= in_op;
        out_last <= in_last;
    end

endmodule

// File: rtl/pipe_reduce.sv
// Fully pipelined bitwise OR/AND/XOR reduction of WIDTH-bit beats with a
// packet accumulator. Latency from accepted last beat to out_valid is L+1.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     beat present; in_data/in_op/in_last ignored otherwise
//   in_data      WIDTH-bit vector to reduce
//   in_op        0=OR 1=AND 2=XOR 3=OR
//   in_last      final beat of the packet
//   out_valid    one-cycle result pulse
//   out_data     reduction of the whole packet
//   out_op       op of the packet's last beat
module pipe_reduce
    import pipe_reduce_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int FANIN = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    output logic             out_data,
    output logic [1:0]       out_op
);

    localparam int L     = num_levels(WIDTH, FANIN);
    localparam int TOT_W = level_offset(WIDTH, FANIN, L + 1);

    // All level outputs packed back to back; level 0 is the raw input and
    // the final level is the single tree bit at the top of the bus.
    logic [TOT_W-1:0] data_p;
    logic             vld_p  [0:L];
    logic [1:0]       op_p   [0:L];
    logic             last_p [0:L];

    assign data_p[WIDTH-1:0] = in_data;
    assign vld_p[0]          = in_valid;
    assign op_p[0]           = in_op;
    assign last_p[0]         = in_last;

    genvar k;
    generate
        for (k = 1; k <= L; k++) begin : g_lvl
            localparam int IW = level_width(WIDTH, FANIN, k - 1);
            localparam int OW = level_width(WIDTH, FANIN, k);
            localparam int IO = level_offset(WIDTH, FANIN, k - 1);
            localparam int OO = level_offset(WIDTH, FANIN, k);

            pipe_reduce_level #(
                .IN_W  (IW),
                .FANIN (FANIN)
            ) u_level (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (vld_p[k-1]),
                .in_data   (data_p[IO +: IW]),
                .in_op     (op_p[k-1]),
                .in_last   (last_p[k-1]),
                .out_valid (vld_p[k]),
                .out_data  (data_p[OO +: OW]),
                .out_op    (op_p[k]),
                .out_last  (last_p[k])
            );
        end
    endgenerate

    logic tree_bit;
    logic pkt_first;
    logic acc_q;
    logic comb_r;

    assign tree_bit = data_p[TOT_W-1];

    // Taking the tree bit directly on a packet's first beat is the same as
    // seeding acc with the identity of that beat's op.
    always_comb begin
        comb_r = pkt_first ? tree_bit : op_apply(op_p[L], acc_q, tree_bit);
    end

    // ---- stage boundary: accumulator and output registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_op    <= 2'd0;
            acc_q     <= 1'b0;
            pkt_first <= 1'b1;
        end else begin
            out_valid <= vld_p[L] && last_p[L];
            if (vld_p[L]) begin
                if (last_p[L]) begin
                    out_data  <= comb_r;
                    out_op    <= op_p[L];
                    pkt_first <= 1'b1;
                end else begin
                    acc_q     <= comb_r;
                    pkt_first <= 1'b0;
                end
            end
        end
    end

endmodule
